mbc_core_seq: RTL and testbench
===============================

// Module: mbc_core_seq
// PURPOSE
//  Parametrised MBox core-memory request sequencer; successor to the fixed four-word MBC bus control.
//  Accepts a start strobe with word mask, address and direction, then drives MEM START, RQ<n>, RD/WR RQ, address and parity.
//  Tracks ACKN and per-word DATA VALID from the memory bus, and reports each returned word and cycle completion to the cache/MB side.
//  Detects non-existent memory by NXM ACKN or an internal timeout.
// PARAMETERS
//  WORDS       4    words per memory cycle (power of 2, 2..16); width of RQ mask
//  ADR_W       22   physical address width (PA 14:35)
//  SYNC_STAGES 2    synchroniser depth on memory-bus inputs (>=2)
//  TMO_W       8    timeout counter width
//  TMO_CYC     200  cycles without ACKN/DATA VALID before NXM (< 2**TMO_W)
// PORTS
//  clk_mbc_h           in   1        MBox clock
//  mr_reset_l          in   1        async active-low master reset
//  ccl_start_mem_h     in   1        start strobe; sampled only in IDLE
//  rq_wr_h             in   1        1=write cycle, 0=read cycle
//  rq_mask_h           in   WORDS    words requested
//  rq_adr_h            in   ADR_W    address; low $clog2(WORDS) bits = first word
//  mem_ackn_h          in   1        memory ACKN, async
//  mem_data_valid_h    in   1        memory DATA VALID, async, one assertion per word
//  nxm_ackn_h          in   1        external NXM acknowledge, async
//  mem_busy_h          out  1        sequencer not IDLE
//  mem_start_h         out  1        MEM START to bus
//  mem_rq_h            out  WORDS    RQ<n> to bus
//  mem_rd_rq_h         out  1        read request
//  mem_wr_rq_h         out  1        write request
//  mem_adr_h           out  ADR_W    registered address
//  mem_adr_par_h       out  1        odd parity over mem_adr_h
//  core_data_valid_h   out  1        one-cycle pulse per returned read word
//  core_word_h         out  $clog2(WORDS) index of word for the current core_data_valid_h
//  cycle_done_h        out  1        one-cycle pulse at end of cycle, normal or NXM
//  nxm_err_h           out  1        sticky NXM flag; cleared on next accepted start
// BEHAVIOUR
//  Reset: every output 0, state IDLE, mask/counters 0. Reset mid-cycle aborts with no cycle_done_h pulse.
//  Inputs through SYNC_STAGES flops + rising-edge detect (ack_e, dv_e, nxm_e); bus events lag by SYNC_STAGES+1 cycles.
//  States: IDLE -> START -> WAIT_ACK -> {DATA (read) | DONE (write)}; DATA -> DONE; DONE -> IDLE.
//  IDLE: start & mask!=0 latches mask/adr/wr and clears nxm_err_h. Next cycle is START.
//    Zero mask: start is ignored, with no pulse.
//  START: one cycle; mem_start_h=1. mem_rq_h and rd/wr rq are asserted from START until ack_e is taken.
//  WAIT_ACK: ack_e -> DATA (read) or DONE (write).
//    dv_e before ack_e is an implicit ACKN plus the first word.
//    nxm_e -> nxm_err_h=1, DONE.
//  DATA: each dv_e pulses core_data_valid_h and sets core_word_h = next set mask bit, searching from first word upward mod WORDS (wrap).
//    That mask bit is then cleared. When the last bit is cleared -> DONE.
//  DONE: cycle_done_h=1 for one cycle -> IDLE.
//  Timeout: counter clears on entering WAIT_ACK and on each dv_e. Reaching TMO_CYC in WAIT_ACK/DATA -> nxm_err_h=1, DONE.
//    When ack_e/dv_e coincide with expiry, the bus event wins and the counter clears.
//  ccl_start_mem_h while busy is ignored, with no queuing.
//  mem_adr_par_h = ~^mem_adr_h, registered with the address.
// CONFIGURATION
//  MBC_NXM_TIMER_EN defined: internal timeout counter active as above.
//  MBC_NXM_TIMER_EN undefined: no counter. NXM is only via nxm_ackn_h, and the sequencer waits indefinitely for ACKN/DATA VALID.
// STRUCTURE
//  Package mbc_pkg:
//    - mbc_state_t enum (IDLE, START, WAIT_ACK, DATA, DONE)
//    - function next_word(mask, first) (wrap-around priority pick)
//    - MBC_WORDS_MAX constant
//  Sub-module mbc_sync: SYNC_STAGES synchroniser + rising-edge pulse; three instances (ackn, data valid, nxm).
// TESTING
//  Read, WORDS=4, mask=4'b1111, adr low=2'b10, ACKN then 4 DATA VALIDs -> core_word_h 2,3,0,1; cycle_done_h after 4th; nxm_err_h=0.
//  Write, mask=4'b0011 -> mem_wr_rq_h/mem_rq_h=0011 until ACKN; cycle_done_h SYNC_STAGES+2 cycles after ACKN edge; no core_data_valid_h.
//  Read, mask=4'b1000, no ACKN (timer enabled, TMO_CYC=200) -> nxm_err_h=1 and cycle_done_h at 200th WAIT_ACK cycle. Next start clears nxm_err_h.
//  DATA VALID arrives before ACKN; start during busy; zero-mask start -> implicit ACK + word 0 delivered; start ignored; zero-mask start gives no outputs.
//  mr_reset_l low during DATA, after 1 of 4 words -> all outputs 0 immediately. A fresh start afterwards behaves like the first scenario.

Source files
------------

// File: rtl/mbc_pkg.sv
// rtl/mbc_pkg.sv - shared types and helpers for the MBox core-memory sequencer
package mbc_pkg;

    localparam int MBC_WORDS_MAX = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        WAIT_ACK = 3'd2,
        DATA     = 3'd3,
        DONE     = 3'd4
    } mbc_state_t;

    // First set bit of mask at or after 'first', wrapping modulo 'words'.
    function automatic logic [3:0] next_word(input logic [MBC_WORDS_MAX-1:0] mask,
                                             input logic [3:0]               first,
                                             input int                       words);
        logic [3:0] pick;
        logic [3:0] idx;
        pick = first;
        for (int i = MBC_WORDS_MAX - 1; i >= 0; i--) begin
            if (i < words) begin
                idx = 4'((int'(first) + i) % words);
                if (mask[idx]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mbc_core_seq_if.sv
// rtl/mbc_core_seq_if.sv - cache/MB side and memory-bus signals of the sequencer
interface mbc_core_seq_if #(
    parameter int WORDS = 4,
    parameter int ADR_W = 22
);
    localparam int WI = $clog2(WORDS);

    logic             ccl_start_mem_h;
    logic             rq_wr_h;
    logic [WORDS-1:0] rq_mask_h;
    logic [ADR_W-1:0] rq_adr_h;
    logic             mem_ackn_h;
    logic             mem_data_valid_h;
    logic             nxm_ackn_h;
    logic             mem_busy_h;
    logic             mem_start_h;
    logic [WORDS-1:0] mem_rq_h;
    logic             mem_rd_rq_h;
    logic             mem_wr_rq_h;
    logic [ADR_W-1:0] mem_adr_h;
    logic             mem_adr_par_h;
    logic             core_data_valid_h;
    logic [WI-1:0]    core_word_h;
    logic             cycle_done_h;
    logic             nxm_err_h;

    modport master (
        input  ccl_start_mem_h, rq_wr_h, rq_mask_h, rq_adr_h,
        input  mem_ackn_h, mem_data_valid_h, nxm_ackn_h,
        output mem_busy_h, mem_start_h, mem_rq_h, mem_rd_rq_h, mem_wr_rq_h,
        output mem_adr_h, mem_adr_par_h, core_data_valid_h, core_word_h,
        output cycle_done_h, nxm_err_h
    );

    modport slave (
        output ccl_start_mem_h, rq_wr_h, rq_mask_h, rq_adr_h,
        output mem_ackn_h, mem_data_valid_h, nxm_ackn_h,
        input  mem_busy_h, mem_start_h, mem_rq_h, mem_rd_rq_h, mem_wr_rq_h,
        input  mem_adr_h, mem_adr_par_h, core_data_valid_h, core_word_h,
        input  cycle_done_h, nxm_err_h
    );
endinterface

// File: rtl/mbc_sync.sv
// rtl/mbc_sync.sv - multi-flop synchroniser with registered rising-edge pulse
module mbc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic pulse
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              pulse_q, pulse_d;

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], d};
        prev_d  = sync_q[STAGES-1];
        pulse_d = sync_q[STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/mbc_core_seq.sv
// rtl/mbc_core_seq.sv - MBox core-memory request sequencer; MBC_NXM_TIMER_EN enables the NXM timeout
module mbc_core_seq
    import mbc_pkg::*;
#(
    parameter int WORDS       = 4,
    parameter int ADR_W       = 22,
    parameter int SYNC_STAGES = 2,
    parameter int TMO_W       = 8,
    parameter int TMO_CYC     = 200
) (
    input  logic           clk_mbc_h,
    input  logic           mr_reset_l,
    mbc_core_seq_if.master bus
);
    localparam int WI = $clog2(WORDS);
    localparam logic [2:0] S_IDLE  = IDLE;
    localparam logic [2:0] S_START = START;
    localparam logic [2:0] S_WAIT  = WAIT_ACK;
    localparam logic [2:0] S_DATA  = DATA;
    localparam logic [2:0] S_DONE  = DONE;
`ifdef MBC_NXM_TIMER_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic ack_e, dv_e, nxm_e;

    mbc_sync #(.STAGES(SYNC_STAGES)) u_sync_ack (.clk(clk_mbc_h), .rst_n(mr_reset_l), .d(bus.mem_ackn_h),       .pulse(ack_e));
    mbc_sync #(.STAGES(SYNC_STAGES)) u_sync_dv  (.clk(clk_mbc_h), .rst_n(mr_reset_l), .d(bus.mem_data_valid_h), .pulse(dv_e));
    mbc_sync #(.STAGES(SYNC_STAGES)) u_sync_nxm (.clk(clk_mbc_h), .rst_n(mr_reset_l), .d(bus.nxm_ackn_h),       .pulse(nxm_e));

    logic [2:0]       state_q, state_d;
    logic [WORDS-1:0] mask_q, mask_d, mask_rest;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic             par_q, par_d, wr_q, wr_d, nxm_q, nxm_d, cdv_q, cdv_d;
    logic [WI-1:0]    word_q, word_d, pick;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_clr, tmo_run, expire, take;

    assign pick      = WI'(next_word(MBC_WORDS_MAX'(mask_q), 4'(adr_q[WI-1:0]), WORDS));
    assign mask_rest = mask_q & ~(WORDS'(1) << pick);

    // Without the timer build the counter is held at zero and never expires.
    always_comb begin
        tmo_clr = (state_q == S_START) || ((state_q == S_WAIT) && (ack_e || dv_e))
                  || ((state_q == S_DATA) && dv_e);
        tmo_run = (state_q == S_WAIT) || (state_q == S_DATA);
        if (!TMO_EN || tmo_clr) tmo_d = '0;
        else if (tmo_run)       tmo_d = tmo_q + 1'b1;
        else                    tmo_d = tmo_q;
        expire = TMO_EN && tmo_run && (tmo_q == TMO_W'(TMO_CYC - 1));
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        adr_d   = adr_q;
        par_d   = par_q;
        wr_d    = wr_q;
        nxm_d   = nxm_q;
        cdv_d   = 1'b0;
        word_d  = word_q;
        take    = 1'b0;
        case (state_q)
            S_IDLE: if (bus.ccl_start_mem_h && (|bus.rq_mask_h)) begin
                mask_d  = bus.rq_mask_h;
                adr_d   = bus.rq_adr_h;
                par_d   = ~^bus.rq_adr_h;
                wr_d    = bus.rq_wr_h;
                nxm_d   = 1'b0;
                state_d = S_START;
            end
            S_START: state_d = S_WAIT;
            // A DATA VALID ahead of ACKN stands in for the ACKN on reads.
            S_WAIT: begin
                if (ack_e || dv_e) begin
                    if (wr_q)      state_d = S_DONE;
                    else if (dv_e) take    = 1'b1;
                    else           state_d = S_DATA;
                end else if (nxm_e || expire) begin
                    nxm_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DATA: begin
                if (dv_e) take = 1'b1;
                else if (expire) begin
                    nxm_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (take) begin
            cdv_d   = 1'b1;
            word_d  = pick;
            mask_d  = mask_rest;
            state_d = (mask_rest == '0) ? S_DONE : S_DATA;
        end
    end

    always_ff @(posedge clk_mbc_h or negedge mr_reset_l) begin
        if (!mr_reset_l) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            adr_q   <= '0;
            par_q   <= 1'b0;
            wr_q    <= 1'b0;
            nxm_q   <= 1'b0;
            cdv_q   <= 1'b0;
            word_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            adr_q   <= adr_d;
            par_q   <= par_d;
            wr_q    <= wr_d;
            nxm_q   <= nxm_d;
            cdv_q   <= cdv_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
        end
    end

    logic rq_on;
    assign rq_on                 = (state_q == S_START) || (state_q == S_WAIT);
    assign bus.mem_busy_h        = (state_q != S_IDLE);
    assign bus.mem_start_h       = (state_q == S_START);
    assign bus.mem_rq_h          = rq_on ? mask_q : '0;
    assign bus.mem_rd_rq_h       = rq_on & ~wr_q;
    assign bus.mem_wr_rq_h       = rq_on & wr_q;
    assign bus.mem_adr_h         = adr_q;
    assign bus.mem_adr_par_h     = par_q;
    assign bus.core_data_valid_h = cdv_q;
    assign bus.core_word_h       = word_q;
    assign bus.cycle_done_h      = (state_q == S_DONE);
    assign bus.nxm_err_h         = nxm_q;
endmodule

// File: tb/tb_mbc_core_seq.sv
// tb/tb_mbc_core_seq.sv - randomized self-checking bench for mbc_core_seq against a transaction-level model
module tb_mbc_core_seq;
    localparam int WORDS = 4, ADR_W = 22, SS = 2, TMO_W = 8, TMO_CYC = 200, WI = 2;
`ifdef MBC_NXM_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif
    localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_DATA = 3, P_DONE = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mbc_core_seq_if #(.WORDS(WORDS), .ADR_W(ADR_W)) bus ();

    mbc_core_seq #(.WORDS(WORDS), .ADR_W(ADR_W), .SYNC_STAGES(SS), .TMO_W(TMO_W), .TMO_CYC(TMO_CYC)) dut (
        .clk_mbc_h (clk),
        .mr_reset_l(rst_n),
        .bus       (bus)
    );

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, done_base = 0, cdv_cnt = 0;
    logic done_nxm = 1'b0;
    int obs_words[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: bus events seen SS+1 cycles late; a cycle is a list of words in delivery order.
    int               m_phase, m_word, m_tmo;
    int               m_words[$];
    logic [WORDS-1:0] m_mask;
    logic [ADR_W-1:0] m_adr;
    logic             m_par, m_wr, m_nxm, m_cdv;
    logic [SS+2:0]    h_ack, h_dv, h_nxm;

    always @(posedge clk or negedge rst_n) begin
        logic ea, ed, en;
        if (!rst_n) begin
            m_phase = P_IDLE; m_word = 0; m_tmo = 0; m_words.delete();
            m_mask = '0; m_adr = '0; m_par = 0; m_wr = 0; m_nxm = 0; m_cdv = 0;
            h_ack = '0; h_dv = '0; h_nxm = '0;
        end else begin
            h_ack = {h_ack[SS+1:0], bus.mem_ackn_h};
            h_dv  = {h_dv[SS+1:0], bus.mem_data_valid_h};
            h_nxm = {h_nxm[SS+1:0], bus.nxm_ackn_h};
            ea = h_ack[SS+1] & ~h_ack[SS+2];
            ed = h_dv[SS+1] & ~h_dv[SS+2];
            en = h_nxm[SS+1] & ~h_nxm[SS+2];
            m_cdv = 1'b0;
            case (m_phase)
                P_IDLE: if (bus.ccl_start_mem_h && bus.rq_mask_h != 0) begin
                    m_mask = bus.rq_mask_h; m_adr = bus.rq_adr_h; m_par = ~^bus.rq_adr_h;
                    m_wr = bus.rq_wr_h; m_nxm = 1'b0; m_words.delete();
                    for (int i = 0; i < WORDS; i++)
                        if (m_mask[(m_adr % WORDS + i) % WORDS]) m_words.push_back(int'((m_adr % WORDS + i) % WORDS));
                    m_phase = P_START;
                end
                P_START: begin m_phase = P_WAIT; m_tmo = 0; end
                P_WAIT, P_DATA: begin
                    if (ed || (ea && m_phase == P_WAIT)) begin
                        m_tmo = 0;
                        if (m_wr) m_phase = P_DONE;
                        else if (ed) begin
                            m_word = m_words.pop_front(); m_cdv = 1'b1;
                            m_phase = (m_words.size() == 0) ? P_DONE : P_DATA;
                        end else m_phase = P_DATA;
                    end else if ((en && m_phase == P_WAIT) || (TMR && m_tmo == TMO_CYC - 1)) begin
                        m_nxm = 1'b1; m_phase = P_DONE;
                    end else m_tmo++;
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic rq_on;
        rq_on = (m_phase == P_START) || (m_phase == P_WAIT);
        chk("busy",  bus.mem_busy_h,        m_phase != P_IDLE);
        chk("start", bus.mem_start_h,       m_phase == P_START);
        chk("rq",    bus.mem_rq_h,          rq_on ? m_mask : '0);
        chk("rd_rq", bus.mem_rd_rq_h,       rq_on & ~m_wr);
        chk("wr_rq", bus.mem_wr_rq_h,       rq_on & m_wr);
        chk("adr",   bus.mem_adr_h,         m_adr);
        chk("par",   bus.mem_adr_par_h,     m_par);
        chk("cdv",   bus.core_data_valid_h, m_cdv);
        chk("word",  bus.core_word_h,       m_word);
        chk("done",  bus.cycle_done_h,      m_phase == P_DONE);
        chk("nxm",   bus.nxm_err_h,         m_nxm);
        if (bus.core_data_valid_h) begin obs_words.push_back(int'(bus.core_word_h)); cdv_cnt++; end
        if (bus.cycle_done_h) begin done_cnt++; done_nxm = bus.nxm_err_h; end
    end

    task automatic cyc(input int n);
        if (n > 0) begin repeat (n) @(negedge clk); #1; end
    endtask

    task automatic start(input logic wr, input logic [WORDS-1:0] mask, input logic [ADR_W-1:0] adr);
        bus.rq_wr_h = wr; bus.rq_mask_h = mask; bus.rq_adr_h = adr;
        bus.ccl_start_mem_h = 1'b1;
        done_base = done_cnt;
        cyc(1);
        bus.ccl_start_mem_h = 1'b0;
    endtask

    task automatic pulse(input int which);
        case (which)
            0:       bus.mem_ackn_h = 1'b1;
            1:       bus.mem_data_valid_h = 1'b1;
            default: bus.nxm_ackn_h = 1'b1;
        endcase
        cyc($urandom_range(1, 2));
        bus.mem_ackn_h = 1'b0; bus.mem_data_valid_h = 1'b0; bus.nxm_ackn_h = 1'b0;
        cyc($urandom_range(1, 3));
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (done_cnt == done_base && k < limit) begin cyc(1); k++; end
        chk("cycle_done_seen", done_cnt != done_base, 1);
        cyc(1);
    endtask

    task automatic read_full_2301();
        int exp_w[4] = '{2, 3, 0, 1};
        obs_words.delete();
        start(1'b0, 4'b1111, 22'h12346);
        cyc(2);
        pulse(0);
        repeat (4) pulse(1);
        wait_done(60);
        chk("rd4_nwords", obs_words.size(), 4);
        for (int i = 0; i < 4 && i < obs_words.size(); i++) chk("rd4_word", obs_words[i], exp_w[i]);
        chk("rd4_nxm", done_nxm, 0);
    endtask

    initial begin
        int n, snap;
        logic [WORDS-1:0] mask;
        logic wr;
        int mode;
        bus.ccl_start_mem_h = 0; bus.rq_wr_h = 0; bus.rq_mask_h = '0; bus.rq_adr_h = '0;
        bus.mem_ackn_h = 0; bus.mem_data_valid_h = 0; bus.nxm_ackn_h = 0;
        #1 rst_n = 1'b0;
        cyc(3);
        chk("rst_busy", bus.mem_busy_h, 0);
        chk("rst_par", bus.mem_adr_par_h, 0);
        rst_n = 1'b1;
        cyc(2);

        read_full_2301();

        snap = cdv_cnt;
        start(1'b1, 4'b0011, 22'h0abcd);
        cyc(3);
        chk("wr_rq_mask", bus.mem_rq_h, 4'b0011);
        chk("wr_rq_wr", bus.mem_wr_rq_h, 1);
        chk("wr_rq_rd", bus.mem_rd_rq_h, 0);
        bus.mem_ackn_h = 1'b1;
        n = 0;
        while (!bus.cycle_done_h && n < 40) begin cyc(1); n++; end
        chk("wr_done_latency", n, SS + 2);
        bus.mem_ackn_h = 1'b0;
        cyc(2);
        chk("wr_no_cdv", cdv_cnt, snap);

        start(1'b0, 4'b1000, 22'h00010);
        n = 0;
        for (int k = 0; k < 600 && done_cnt == done_base; k++) begin
            if (!TMR && k == 30) bus.nxm_ackn_h = 1'b1;
            if (!TMR && k == 32) bus.nxm_ackn_h = 1'b0;
            if (bus.mem_rd_rq_h && !bus.mem_start_h) n++;
            cyc(1);
        end
        chk("nxm_done_flag", done_nxm, 1);
        chk("nxm_sticky", bus.nxm_err_h, 1);
        if (TMR) chk("tmo_wait_cycles", n, TMO_CYC);
        cyc(1);
        start(1'b1, 4'b0001, 22'h00020);
        chk("nxm_cleared", bus.nxm_err_h, 0);
        cyc(1);
        pulse(0);
        wait_done(40);

        obs_words.delete();
        start(1'b0, 4'b0101, 22'h00100);
        cyc(2);
        pulse(1);
        bus.rq_mask_h = 4'b1111; bus.ccl_start_mem_h = 1'b1;
        cyc(1);
        bus.ccl_start_mem_h = 1'b0;
        pulse(1);
        wait_done(40);
        chk("dvfirst_n", obs_words.size(), 2);
        if (obs_words.size() == 2) begin
            chk("dvfirst_w0", obs_words[0], 0);
            chk("dvfirst_w1", obs_words[1], 2);
        end
        snap = done_cnt;
        start(1'b0, 4'b0000, 22'h3ffff);
        cyc(3);
        chk("zero_mask_busy", bus.mem_busy_h, 0);
        chk("zero_mask_done", done_cnt, snap);

        snap = cdv_cnt;
        start(1'b0, 4'b1111, 22'h00200);
        cyc(2);
        pulse(0);
        pulse(1);
        n = 0;
        while (cdv_cnt == snap && n < 40) begin cyc(1); n++; end
        chk("rst_mid_word1", cdv_cnt, snap + 1);
        snap = done_cnt;
        cyc(1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_busy", bus.mem_busy_h, 0);
        chk("rstm_rq", bus.mem_rq_h, 0);
        chk("rstm_rd", bus.mem_rd_rq_h, 0);
        chk("rstm_adr", bus.mem_adr_h, 0);
        chk("rstm_par", bus.mem_adr_par_h, 0);
        chk("rstm_cdv", bus.core_data_valid_h, 0);
        chk("rstm_word", bus.core_word_h, 0);
        chk("rstm_done", bus.cycle_done_h, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        chk("rstm_no_done", done_cnt, snap);
        read_full_2301();

        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom_range(0, 1));
            mask = WORDS'($urandom);
            if ($urandom_range(0, 9) == 0) mask = '0;
            start(wr, mask, ADR_W'($urandom));
            if (mask == '0) begin cyc(2); continue; end
            cyc($urandom_range(0, 4));
            mode = $urandom_range(0, 9);
            if ($urandom_range(0, 2) == 0) begin
                bus.rq_mask_h = WORDS'($urandom); bus.ccl_start_mem_h = 1'b1;
                cyc(1);
                bus.ccl_start_mem_h = 1'b0;
            end
            if (mode == 0) pulse(2);
            else if (!wr && mode <= 3) repeat ($countones(mask)) pulse(1);
            else begin
                pulse(0);
                if (!wr) repeat ($countones(mask)) pulse(1);
            end
            wait_done(300);
            cyc($urandom_range(1, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
